// File: rtl/dstack_spill_control_pkg.sv
// Shared definitions for the data-stack spill/fill controller:
// core movement encodings and controller FSM states.
package dstack_spill_control_pkg;

   localparam int unsigned OccWidth = 6;

   typedef enum logic [1:0] {
      MoveHold = 2'b00,
      MovePush = 2'b01,
      MovePop1 = 2'b10,
      MovePop2 = 2'b11
   } movement_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StSpill = 2'b01,
      StFill  = 2'b10
   } state_e;

endpackage

// File: rtl/dstack_spill_control.sv
// Data-stack spill/fill controller: tracks on-chip occupancy, spills the bottom entry to
// memory above the high-water mark and refills from memory below the low-water mark.
module dstack_spill_control
   import dstack_spill_control_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned HIGH_WATER = 28,
   parameter int unsigned LOW_WATER  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  step,
   input  logic [1:0]            movement,
   input  logic [WORD_WIDTH-1:0] bottom_value,
   input  logic [WORD_WIDTH-1:0] stack_base,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [WORD_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [WORD_WIDTH-1:0] mem_rdata,
   output logic                  spill_done,
   output logic                  fill_valid,
   output logic [WORD_WIDTH-1:0] fill_value,
   output logic                  stall,
   output logic                  underflow,
   output logic [OccWidth-1:0]   occupancy,
   output logic [WORD_WIDTH-1:0] mem_count
);

   localparam logic [OccWidth-1:0]   DepthOcc = OccWidth'(DEPTH);
   localparam logic [OccWidth-1:0]   HighOcc  = OccWidth'(HIGH_WATER);
   localparam logic [OccWidth-1:0]   LowOcc   = OccWidth'(LOW_WATER);
   localparam logic [WORD_WIDTH-1:0] WordOne  = WORD_WIDTH'(1);

   state_e                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  spill_done_q, spill_done_d;
   logic                  fill_valid_q, fill_valid_d;
   logic [WORD_WIDTH-1:0] fill_value_q, fill_value_d;
   logic                  underflow_q, underflow_d;
   logic [OccWidth-1:0]   occupancy_q, occupancy_d;
   logic [WORD_WIDTH-1:0] mem_count_q, mem_count_d;

   logic                  push, pop_short, mem_empty, mem_full;
   logic                  stall_full, stall_fill, stall_spill, retire;
   logic                  ack_ok, spill_ack, fill_ack;
   logic [1:0]            pop_cnt, pop_ret;
   logic [OccWidth-1:0]   pop_ext;
   logic [OccWidth+1:0]   occ_add, occ_sub;

   // Core-side decode and stall generation
   always_comb begin
      push    = step && (movement == MovePush);
      pop_cnt = 2'd0;
      if (step) begin
         case (movement)
            MovePop1: pop_cnt = 2'd1;
            MovePop2: pop_cnt = 2'd2;
            default:  pop_cnt = 2'd0;
         endcase
      end
      pop_ext     = {{(OccWidth-2){1'b0}}, pop_cnt};
      mem_empty   = (mem_count_q == '0);
      mem_full    = &mem_count_q;
      pop_short   = (pop_ext > occupancy_q);
      stall_full  = push && (occupancy_q == DepthOcc);
      stall_fill  = pop_short && !mem_empty;
      // Keep the latched bottom entry on chip until its spill is acknowledged.
      stall_spill = (state_q == StSpill) && (pop_cnt != 2'd0) && (pop_ext >= occupancy_q);
   end

   assign stall  = stall_full | stall_fill | stall_spill;
   assign retire = step && !stall;
   assign ack_ok = mem_ack && mem_req_q;

   // Controller FSM and memory request registers
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      spill_done_d = 1'b0;
      fill_valid_d = 1'b0;
      fill_value_d = fill_value_q;
      mem_count_d  = mem_count_q;
      spill_ack    = 1'b0;
      fill_ack     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if ((occupancy_q >= HighOcc) && !mem_full) begin
               state_d     = StSpill;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = stack_base + mem_count_q;
               mem_wdata_d = bottom_value;
            end else if ((occupancy_q < LowOcc) && !mem_empty) begin
               state_d    = StFill;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = stack_base + mem_count_q - WordOne;
            end
         end
         StSpill: begin
            if (ack_ok) begin
               state_d      = StIdle;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               spill_ack    = 1'b1;
               spill_done_d = 1'b1;
               mem_count_d  = mem_count_q + WordOne;
            end
         end
         StFill: begin
            if (ack_ok) begin
               state_d      = StIdle;
               mem_req_d    = 1'b0;
               fill_ack     = 1'b1;
               fill_valid_d = 1'b1;
               fill_value_d = mem_rdata;
               mem_count_d  = mem_count_q - WordOne;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Occupancy: core push/pop plus spill/fill movement, saturating at zero on underflow
   always_comb begin
      pop_ret     = retire ? pop_cnt : 2'd0;
      occ_add     = {2'b00, occupancy_q} + {{(OccWidth+1){1'b0}}, push && retire}
                  + {{(OccWidth+1){1'b0}}, fill_ack};
      occ_sub     = {{OccWidth{1'b0}}, pop_ret} + {{(OccWidth+1){1'b0}}, spill_ack};
      occupancy_d = (occ_sub > occ_add) ? '0 : OccWidth'(occ_add - occ_sub);
      underflow_d = underflow_q | (retire && pop_short && mem_empty);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         spill_done_q <= 1'b0;
         fill_valid_q <= 1'b0;
         fill_value_q <= '0;
         underflow_q  <= 1'b0;
         occupancy_q  <= '0;
         mem_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         spill_done_q <= spill_done_d;
         fill_valid_q <= fill_valid_d;
         fill_value_q <= fill_value_d;
         underflow_q  <= underflow_d;
         occupancy_q  <= occupancy_d;
         mem_count_q  <= mem_count_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign spill_done = spill_done_q;
   assign fill_valid = fill_valid_q;
   assign fill_value = fill_value_q;
   assign underflow  = underflow_q;
   assign occupancy  = occupancy_q;
   assign mem_count  = mem_count_q;

endmodule

// File: tb/tb_dstack_spill_control.sv
// Scoreboard bench for dstack_spill_control: directed stimulus queues expected memory
// requests, spill pulses and fill pulses; a negedge monitor checks them as they appear.
module tb_dstack_spill_control;
   import dstack_spill_control_pkg::*;

   localparam logic [31:0] Base = 32'h0000_1000;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [31:0] value;
      logic [31:0] count;
   } fill_t;

   logic        clk, reset_n, step, mem_req, mem_we, mem_ack;
   logic [1:0]  movement;
   logic [31:0] bottom_value, stack_base, mem_addr, mem_wdata, mem_rdata;
   logic        spill_done, fill_valid, stall, underflow;
   logic [31:0] fill_value, mem_count;
   logic [5:0]  occupancy;

   int checks = 0;
   int errors = 0;

   req_t        req_q[$];
   logic [31:0] spill_q[$];
   fill_t       fill_q[$];

   dstack_spill_control dut (
      .clk(clk), .reset_n(reset_n), .step(step), .movement(movement),
      .bottom_value(bottom_value), .stack_base(stack_base),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .spill_done(spill_done),
      .fill_valid(fill_valid), .fill_value(fill_value), .stall(stall),
      .underflow(underflow), .occupancy(occupancy), .mem_count(mem_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Monitor: compares DUT-presented events against the scoreboard queues.
   logic req_prev = 1'b0;
   req_t held;
   always @(negedge clk) begin
      if (!reset_n) begin
         req_prev = 1'b0;
      end else begin
         if (mem_req && !req_prev) begin
            req_t e;
            checks++;
            if (req_q.size() == 0) begin
               errors++;
               $display("FAIL mem_req_unexpected got we=%0b addr=%h required none", mem_we, mem_addr);
            end else begin
               e = req_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                  errors++;
                  $display("FAIL mem_req got we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                           mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
               end
            end
            held = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
         end else if (mem_req && req_prev) begin
            checks++;
            if (mem_we !== held.we || mem_addr !== held.addr || mem_wdata !== held.wdata) begin
               errors++;
               $display("FAIL mem_req_hold got we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                        mem_we, mem_addr, mem_wdata, held.we, held.addr, held.wdata);
            end
         end
         if (spill_done) begin
            checks++;
            if (spill_q.size() == 0) begin
               errors++;
               $display("FAIL spill_done_unexpected got mem_count=%0d required none", mem_count);
            end else begin
               logic [31:0] c;
               c = spill_q.pop_front();
               if (mem_count !== c) begin
                  errors++;
                  $display("FAIL spill_done_count got %0d required %0d", mem_count, c);
               end
            end
         end
         if (fill_valid) begin
            checks++;
            if (fill_q.size() == 0) begin
               errors++;
               $display("FAIL fill_valid_unexpected got value=%h required none", fill_value);
            end else begin
               fill_t f;
               f = fill_q.pop_front();
               if (fill_value !== f.value || mem_count !== f.count) begin
                  errors++;
                  $display("FAIL fill_valid got value=%h count=%0d required value=%h count=%0d",
                           fill_value, mem_count, f.value, f.count);
               end
            end
         end
         req_prev = mem_req;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic move(input logic [1:0] mv, input int n);
      step = 1'b1;
      movement = mv;
      repeat (n) tick();
      step = 1'b0;
      movement = MoveHold;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!mem_req && n < 50) begin
         tick();
         n++;
      end
      if (!mem_req) begin
         checks++;
         errors++;
         $display("FAIL %s got no mem_req required mem_req within 50 cycles", name);
      end
   endtask

   task automatic do_ack(input int delay, input logic [31:0] rdata);
      repeat (delay) tick();
      mem_ack = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_spill_done"}, spill_done, 0);
      chk({tag, "_fill_valid"}, fill_valid, 0);
      chk({tag, "_fill_value"}, fill_value, 0);
      chk({tag, "_underflow"}, underflow, 0);
      chk({tag, "_occupancy"}, occupancy, 0);
      chk({tag, "_mem_count"}, mem_count, 0);
   endtask

   initial begin
      reset_n = 1'b0; step = 1'b0; movement = MoveHold; mem_ack = 1'b0; mem_rdata = '0;
      stack_base = Base; bottom_value = 32'hB0B0_0001;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      chk("reset_stall", stall, 0);
      reset_n = 1'b1;
      tick();

      // 28 pushes from reset: spill of the bottom entry, acked after 2 cycles
      req_q.push_back('{we: 1'b1, addr: Base, wdata: 32'hB0B0_0001});
      spill_q.push_back(32'd1);
      move(MovePush, 28);
      chk("s1_occ_28", occupancy, 28);
      wait_req("s1_req");
      do_ack(2, '0);
      chk("s1_occ", occupancy, 27);
      chk("s1_mem_count", mem_count, 1);
      chk("s1_req_dropped", mem_req, 0);

      // One more push: second spill acked in its first request cycle
      bottom_value = 32'hB0B0_0002;
      req_q.push_back('{we: 1'b1, addr: Base + 1, wdata: 32'hB0B0_0002});
      spill_q.push_back(32'd2);
      move(MovePush, 1);
      wait_req("s2_req");
      do_ack(0, '0);
      chk("s2_occ", occupancy, 27);
      chk("s2_mem_count", mem_count, 2);

      // Pop down to 3, then pop: fill from Base+1
      move(MovePop1, 24);
      chk("s3_occ_3", occupancy, 3);
      req_q.push_back('{we: 1'b0, addr: Base + 1, wdata: '0});
      fill_q.push_back('{value: 32'hF111_0001, count: 32'd1});
      move(MovePop1, 1);
      chk("s3_occ_2", occupancy, 2);
      chk("s3_fill_req", mem_req, 1);
      move(MovePop1, 1);
      chk("s3_occ_1", occupancy, 1);
      // pop 2 at occupancy 1 with spilled entries: stall until the fill lands
      step = 1'b1; movement = MovePop2;
      #1;
      chk("s3_stall_pop2", stall, 1);
      mem_ack = 1'b1; mem_rdata = 32'hF111_0001;
      tick();
      mem_ack = 1'b0;
      chk("s3_occ_after_fill", occupancy, 2);
      chk("s3_count_after_fill", mem_count, 1);
      chk("s3_stall_released", stall, 0);
      req_q.push_back('{we: 1'b0, addr: Base, wdata: '0});
      fill_q.push_back('{value: 32'hF111_0002, count: 32'd0});
      tick();
      step = 1'b0; movement = MoveHold;
      chk("s3_occ_after_pop2", occupancy, 0);
      chk("s3_no_underflow", underflow, 0);
      wait_req("s3_req2");
      do_ack(0, 32'hF111_0002);
      chk("s3_occ_fill2", occupancy, 1);
      chk("s3_count_fill2", mem_count, 0);
      chk("s3_fill_value", fill_value, 32'hF111_0002);

      // Pop 2 at occupancy 1 with nothing spilled: underflow, no stall
      step = 1'b1; movement = MovePop2;
      #1;
      chk("s4_no_stall", stall, 0);
      tick();
      step = 1'b0; movement = MoveHold;
      chk("s4_underflow", underflow, 1);
      chk("s4_occ_sat", occupancy, 0);
      tick();
      chk("s4_underflow_sticky", underflow, 1);

      // Push at full occupancy while a spill is pending
      do_reset();
      chk("s5_underflow_cleared", underflow, 0);
      bottom_value = 32'hB0B0_0003;
      req_q.push_back('{we: 1'b1, addr: Base, wdata: 32'hB0B0_0003});
      spill_q.push_back(32'd1);
      step = 1'b1; movement = MovePush;
      repeat (32) tick();
      chk("s5_occ_full", occupancy, 32);
      chk("s5_stall_full", stall, 1);
      chk("s5_req_pending", mem_req, 1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("s5_occ_after_ack", occupancy, 31);
      chk("s5_stall_clear", stall, 0);
      req_q.push_back('{we: 1'b1, addr: Base + 1, wdata: 32'hB0B0_0003});
      tick();
      step = 1'b0; movement = MoveHold;
      chk("s5_push_retired", occupancy, 32);
      tick();

      // Push coinciding with a spill ack at occupancy 28
      do_reset();
      bottom_value = 32'hB0B0_0004;
      req_q.push_back('{we: 1'b1, addr: Base, wdata: 32'hB0B0_0004});
      spill_q.push_back(32'd1);
      move(MovePush, 28);
      wait_req("s6_req");
      step = 1'b1; movement = MovePush; mem_ack = 1'b1;
      tick();
      step = 1'b0; movement = MoveHold; mem_ack = 1'b0;
      chk("s6_occ_same", occupancy, 28);
      chk("s6_mem_count", mem_count, 1);
      req_q.push_back('{we: 1'b1, addr: Base + 1, wdata: 32'hB0B0_0004});
      spill_q.push_back(32'd2);
      wait_req("s6_req2");
      do_ack(1, '0);
      chk("s6_occ_27", occupancy, 27);
      chk("s6_mem_count2", mem_count, 2);

      // Reset in the middle of a fill
      move(MovePop1, 24);
      req_q.push_back('{we: 1'b0, addr: Base + 1, wdata: '0});
      wait_req("s7_req");
      tick();
      chk("s7_fill_pending", mem_req, 1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("midfill");
      tick();
      reset_n = 1'b1;
      tick();

      chk("req_q_drained", req_q.size(), 0);
      chk("spill_q_drained", spill_q.size(), 0);
      chk("fill_q_drained", fill_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dstack_spill_control.md
DSTACK_SPILL_CONTROL -- requirements
Module: dstack_spill_control

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, meaning datapath word width.
REQ-002 SHALL have parameter DEPTH, default 32, meaning on-chip data stack entries.
REQ-003 SHALL have parameter HIGH_WATER, default 28, meaning the occupancy at or above which a spill starts.
REQ-004 SHALL have parameter LOW_WATER, default 4, meaning the occupancy below which a fill starts.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port step, input, 1 bit: core retires an instruction this cycle.
REQ-009 SHALL have port movement, input, 2 bits: 00 hold, 01 push 1, 10 pop 1, 11 pop 2.
REQ-010 SHALL have port bottom_value, input, WORD_WIDTH: deepest valid on-chip entry.
REQ-011 SHALL have port stack_base, input, WORD_WIDTH: word address of the memory spill region.
REQ-012 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, WORD_WIDTH), mem_wdata (out, WORD_WIDTH), mem_ack (in, 1), mem_rdata (in, WORD_WIDTH): spill/fill memory port.
REQ-013 SHALL have port spill_done, output, 1 bit: pulse; on-chip stack drops its bottom entry.
REQ-014 SHALL have ports fill_valid (out, 1) and fill_value (out, WORD_WIDTH): pulse; insert fill_value below the bottom entry.
REQ-015 SHALL have port stall, output, 1 bit: combinational; core must not retire this cycle.
REQ-016 SHALL have port underflow, output, 1 bit: sticky error flag.
REQ-017 SHALL have port occupancy, output, 6 bits: valid on-chip entries, 0..DEPTH.
REQ-018 SHALL have port mem_count, output, WORD_WIDTH: number of entries spilled to memory.

Function
REQ-019 SHALL implement FSM states IDLE, SPILL and FILL.
REQ-020 IDLE SHALL go to SPILL when occupancy >= HIGH_WATER; otherwise to FILL when occupancy < LOW_WATER and mem_count > 0; SPILL has priority.
REQ-021 On entering SPILL, SHALL latch bottom_value into mem_wdata and assert mem_req=1, mem_we=1, mem_addr=stack_base+mem_count.
REQ-022 On entering FILL, SHALL assert mem_req=1, mem_we=0, mem_addr=stack_base+mem_count-1.
REQ-023 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack; mem_ack is sampled only while mem_req=1, and ack in the first request cycle is legal.
REQ-024 On SPILL ack, SHALL pulse spill_done for one cycle, increment mem_count, decrement occupancy, deassert mem_req and return to IDLE.
REQ-025 On FILL ack, SHALL register mem_rdata to fill_value, pulse fill_valid the next cycle, decrement mem_count, increment occupancy and return to IDLE.
REQ-026 occupancy_next SHALL equal occupancy + push - pops - spill_ack + fill_ack; all terms may coincide in one cycle, and core terms count only when step=1 and stall=0.
REQ-027 SHALL assert stall when step=1, movement=01 and occupancy=DEPTH.
REQ-028 SHALL assert stall when step=1, the pop count exceeds occupancy and mem_count > 0.
REQ-029 SHALL assert stall in SPILL when a pop would leave occupancy < 1, so the latched bottom entry stays valid.
REQ-030 When the pop count exceeds occupancy and mem_count = 0, SHALL set underflow, saturate occupancy at 0 and not stall.
REQ-031 mem_count SHALL never wrap: a spill is not started when mem_count is all ones.

Reset
REQ-032 On reset_n low, SHALL asynchronously force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, spill_done=0, fill_valid=0, fill_value=0, underflow=0, occupancy=0 and mem_count=0.
REQ-033 Reset during SPILL or FILL SHALL abandon the in-flight request; the memory side tolerates a dropped req.

Structure
REQ-034 SHALL place the movement encodings and the FSM state enum in the shared instruction/definitions package.
REQ-035 SHALL be a single module; no sub-module.

Verification
REQ-036 Bench SHALL push 28 from reset with ack after 2 cycles -> mem_req we=1 at addr stack_base+0; spill_done; occupancy 27; mem_count 1.
REQ-037 Bench SHALL push at occupancy 32 while a spill is pending (no ack) -> stall=1; after ack, occupancy 31 and the push retires.
REQ-038 Bench SHALL pop at occupancy 3 with mem_count 2 -> FILL read at stack_base+1; fill_valid with fill_value=mem_rdata; mem_count 1.
REQ-039 Bench SHALL issue pop 2 at occupancy 1 with mem_count 0 -> underflow=1, occupancy 0, stall=0.
REQ-040 Bench SHALL issue push on the same cycle as a spill ack at occupancy 28 -> occupancy remains 28.
REQ-041 Bench SHALL assert reset_n=0 mid-FILL -> mem_req drops immediately; all outputs return to reset values.
